mmio_uart_tx: RTL and testbench

Memory-mapped serial transmitter that sits on the data-memory bus as a responder beside the data SRAMs, decoded into its own address region. Stores from the CPU backend push bytes into a small FIFO; an 8N1 shifter drains the FIFO onto `tx` at a programmable bit period. Loads return FIFO and transmitter status, so software can poll or take an active-low interrupt.

---
 rtl/mmio_uart_tx_if.sv | 23 ++
 rtl/mmio_uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus responder port of the memory-mapped UART transmitter,
// together with its serial line and interrupt pin.
interface mmio_uart_tx_if;
  logic        cs_n;
  logic        we_n;
  logic        oe_n;
  logic [3:0]  byte_en_n;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_n;

  modport master (
    output cs_n, we_n, oe_n, byte_en_n, addr, wdata,
    input  rdata, tx, irq_n
  );

  modport slave (
    input  cs_n, we_n, oe_n, byte_en_n, addr, wdata,
    output rdata, tx, irq_n
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 transmitter: CPU stores fill a byte FIFO, an FSM shifts
// frames out on tx at a programmable clocks-per-bit period.
module mmio_uart_tx #(
  parameter int DEPTH     = 8,
  parameter int DIV_RESET = 16
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // A programmed period of 0 behaves exactly like 1 clock per bit.
  function automatic logic [15:0] eff_period(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [15:0]      r_div;
  logic             r_txen;
  logic             r_ie;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [15:0]      r_period;
  logic [15:0]      r_bitcnt;
  logic [2:0]       r_nbit;
  logic             r_tx;
  logic             r_irq_n;

  logic             w_wr;
  logic             w_rd;
  logic             w_full_word;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic             w_empty;
  logic             w_full;
  logic             w_busy;
  logic             w_can_start;
  logic             w_bit_end;
  logic [15:0]      w_div_eff;
  logic [7:0]       w_head;
  logic [3:0]       w_count4;
  logic [31:0]      w_rdata;

  state_t           w_state_nxt;
  logic [7:0]       w_shift_nxt;
  logic [15:0]      w_period_nxt;
  logic [15:0]      w_bitcnt_nxt;
  logic [2:0]       w_nbit_nxt;
  logic             w_tx_nxt;

  assign w_wr        = ~bus.cs_n & ~bus.we_n;
  assign w_rd        = ~bus.cs_n & ~bus.oe_n;
  assign w_full_word = (bus.byte_en_n == 4'b0000);
  assign w_push_req  = w_wr & (bus.addr == 2'd0) & ~bus.byte_en_n[0];
  assign w_ovf_clr   = w_wr & (bus.addr == 2'd1) & w_full_word & bus.wdata[3];

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_busy      = (r_state != S_IDLE);
  assign w_can_start = r_txen & ~w_empty;
  assign w_bit_end   = (r_bitcnt == 16'd0);
  assign w_div_eff   = eff_period(r_div);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_count4    = 4'(r_count);

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovf_set = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= 16'(DIV_RESET);
      r_txen <= 1'b0;
      r_ie   <= 1'b0;
    end else if (w_wr && w_full_word) begin
      if (bus.addr == 2'd2) r_div <= bus.wdata[15:0];
      if (bus.addr == 2'd3) begin
        r_txen <= bus.wdata[0];
        r_ie   <= bus.wdata[1];
      end
    end
  end

  // Next-state logic; the period is latched at frame start so DIV writes wait a frame.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_period_nxt = r_period;
    w_bitcnt_nxt = r_bitcnt;
    w_nbit_nxt   = r_nbit;
    w_pop        = 1'b0;
    w_tx_nxt     = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_can_start) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_head;
          w_period_nxt = w_div_eff;
          w_bitcnt_nxt = w_div_eff - 16'd1;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt  = S_DATA;
          w_bitcnt_nxt = r_period - 16'd1;
          w_nbit_nxt   = 3'd0;
        end else begin
          w_bitcnt_nxt = r_bitcnt - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          w_bitcnt_nxt = r_period - 16'd1;
          if (r_nbit == 3'd7) w_state_nxt = S_STOP;
          else                w_nbit_nxt  = r_nbit + 3'd1;
        end else begin
          w_bitcnt_nxt = r_bitcnt - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (w_can_start) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_head;
            w_period_nxt = w_div_eff;
            w_bitcnt_nxt = w_div_eff - 16'd1;
            w_state_nxt  = S_START;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_bitcnt_nxt = r_bitcnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_period <= 16'd1;
      r_bitcnt <= 16'd0;
      r_nbit   <= 3'd0;
      r_tx     <= 1'b1;
      r_irq_n  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_period <= w_period_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_nbit   <= w_nbit_nxt;
      r_tx     <= w_tx_nxt;
      r_irq_n  <= ~(r_ie & w_empty & ~w_busy);
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (bus.addr)
        2'd1:    w_rdata = {24'd0, w_count4, r_ovf, w_busy, w_full, w_empty};
        2'd2:    w_rdata = {16'd0, r_div};
        2'd3:    w_rdata = {30'd0, r_ie, r_txen};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.tx    = r_tx;
  assign bus.irq_n = r_irq_n;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vector table plus frame-level sequences.
module tb_mmio_uart_tx;
  logic clk = 1'b0;
  logic rst;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.DEPTH(8), .DIV_RESET(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [3:0]  be_n;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input logic [1:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] ex);
    vec_t v;
    v.wr = wr; v.addr = a; v.be_n = be; v.wdata = wd; v.exp = ex;
    tbl.push_back(v);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.cs_n = 1'b0; bus.we_n = 1'b0; bus.addr = a; bus.byte_en_n = be; bus.wdata = d;
    @(posedge clk); #1;
    bus.cs_n = 1'b1; bus.we_n = 1'b1; bus.byte_en_n = 4'hF;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.cs_n = 1'b0; bus.oe_n = 1'b0; bus.addr = a;
    #1;
    d = bus.rdata;
    bus.cs_n = 1'b1; bus.oe_n = 1'b1;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] ex);
    logic [31:0] d;
    bus_read(a, d);
    chk(name, d, ex);
  endtask

  // now=1: the start bit is already on tx at the current sample point.
  task automatic capture_frame(input logic [7:0] b, input int div, input bit now, input string name);
    int   gap;
    int   nbad;
    int   d;
    logic e;
    d   = (div == 0) ? 1 : div;
    gap = 0;
    if (!now) begin
      @(posedge clk); #1;
      while (bus.tx !== 1'b0 && gap < 400) begin
        gap++;
        @(posedge clk); #1;
      end
      chk($sformatf("%s start_gap", name), gap, 0);
    end
    for (int k = 0; k < 10; k++) begin
      e    = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      nbad = 0;
      for (int c = 0; c < d; c++) begin
        if (!(k == 0 && c == 0)) begin
          @(posedge clk); #1;
        end
        if (bus.tx !== e) nbad++;
      end
      chk($sformatf("%s bit%0d bad_cycles", name, k), nbad, 0);
    end
  endtask

  task automatic watch_idle(input int cycles, input string name);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.tx !== 1'b1) lows++;
    end
    chk(name, lows, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bus.cs_n = 1'b1; bus.we_n = 1'b1; bus.oe_n = 1'b1;
    bus.byte_en_n = 4'hF; bus.addr = 2'd0; bus.wdata = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por tx", bus.tx, 1'b1);
    chk("por irq_n", bus.irq_n, 1'b1);
    read_chk("por STATUS", 2'd1, 32'h01);
    read_chk("por DIV", 2'd2, 32'h10);
    read_chk("por CTRL", 2'd3, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    bus.cs_n = 1'b0; bus.oe_n = 1'b1; bus.addr = 2'd2;
    #1;
    chk("rdata without oe", bus.rdata, 32'h0);
    bus.cs_n = 1'b1;

    add(0, 2'd2, 4'h0, 32'h0, 32'h10);
    add(1, 2'd2, 4'hE, 32'h3, 32'h0);
    add(0, 2'd2, 4'h0, 32'h0, 32'h10);
    add(1, 2'd2, 4'h0, 32'h1234_ABCD, 32'h0);
    add(0, 2'd2, 4'h0, 32'h0, 32'hABCD);
    add(1, 2'd3, 4'h0, 32'h2, 32'h0);
    add(0, 2'd3, 4'h0, 32'h0, 32'h2);
    add(1, 2'd3, 4'h8, 32'h3, 32'h0);
    add(0, 2'd3, 4'h0, 32'h0, 32'h2);
    add(1, 2'd3, 4'h0, 32'h0, 32'h0);
    add(0, 2'd3, 4'h0, 32'h0, 32'h0);
    add(0, 2'd0, 4'h0, 32'h0, 32'h0);
    add(1, 2'd0, 4'hE, 32'h10, 32'h0);
    add(0, 2'd1, 4'h0, 32'h0, 32'h10);
    for (int i = 1; i < 8; i++) add(1, 2'd0, 4'h0, 32'hFFFF_FF10 + i, 32'h0);
    add(0, 2'd1, 4'h0, 32'h0, 32'h82);
    add(1, 2'd0, 4'hE, 32'h18, 32'h0);
    add(0, 2'd1, 4'h0, 32'h0, 32'h8A);
    add(1, 2'd1, 4'hE, 32'h8, 32'h0);
    add(0, 2'd1, 4'h0, 32'h0, 32'h8A);
    add(1, 2'd0, 4'hD, 32'h99, 32'h0);
    add(0, 2'd1, 4'h0, 32'h0, 32'h8A);
    add(1, 2'd1, 4'h0, 32'h8, 32'h0);
    add(0, 2'd1, 4'h0, 32'h0, 32'h82);
    add(1, 2'd2, 4'h0, 32'h4, 32'h0);
    add(0, 2'd2, 4'h0, 32'h0, 32'h4);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].be_n, tbl[i].wdata);
      end else begin
        bus_read(tbl[i].addr, d);
        chk($sformatf("vec%0d reg%0d", i, tbl[i].addr), d, tbl[i].exp);
      end
    end

    // Drain: eight queued bytes in order, the dropped ninth never appears.
    bus_write(2'd3, 4'h0, 32'h1);
    for (int i = 0; i < 8; i++) capture_frame(8'h10 + 8'(i), 4, 1'b0, $sformatf("drain%0d", i));
    @(posedge clk); #1;
    read_chk("drain STATUS", 2'd1, 32'h01);
    watch_idle(30, "no ninth frame");

    // Single byte.
    bus_write(2'd0, 4'hE, 32'hA5);
    chk("tx high on push edge", bus.tx, 1'b1);
    capture_frame(8'hA5, 4, 1'b0, "single");
    @(posedge clk); #1;
    read_chk("single STATUS", 2'd1, 32'h01);

    // Back-to-back at DIV=2.
    bus_write(2'd3, 4'h0, 32'h0);
    bus_write(2'd2, 4'h0, 32'h2);
    bus_write(2'd0, 4'hE, 32'h00);
    bus_write(2'd0, 4'hE, 32'hFF);
    bus_write(2'd3, 4'h0, 32'h1);
    capture_frame(8'h00, 2, 1'b0, "b2b0");
    capture_frame(8'hFF, 2, 1'b0, "b2b1");

    // DIV change mid-frame only affects the following frame.
    bus_write(2'd3, 4'h0, 32'h0);
    bus_write(2'd0, 4'hE, 32'h3C);
    bus_write(2'd0, 4'hE, 32'hC3);
    bus_write(2'd3, 4'h0, 32'h1);
    fork
      begin
        capture_frame(8'h3C, 2, 1'b0, "divchg0");
        capture_frame(8'hC3, 3, 1'b0, "divchg1");
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus_write(2'd2, 4'h0, 32'h3);
      end
    join

    // Push on the same edge the FSM pops a full FIFO.
    bus_write(2'd3, 4'h0, 32'h0);
    bus_write(2'd2, 4'h0, 32'h2);
    for (int i = 0; i < 8; i++) bus_write(2'd0, 4'hE, 32'h20 + i);
    bus_write(2'd3, 4'h0, 32'h1);
    bus_write(2'd0, 4'hE, 32'h28);
    read_chk("collision STATUS", 2'd1, 32'h86);
    capture_frame(8'h20, 2, 1'b1, "coll0");
    for (int i = 1; i < 9; i++) capture_frame(8'h20 + 8'(i), 2, 1'b0, $sformatf("coll%0d", i));
    @(posedge clk); #1;
    read_chk("collision end STATUS", 2'd1, 32'h01);

    // DIV=0 and interrupt timing.
    bus_write(2'd2, 4'h0, 32'h0);
    read_chk("DIV zero", 2'd2, 32'h0);
    bus_write(2'd3, 4'h0, 32'h3);
    chk("irq_n lags IE", bus.irq_n, 1'b1);
    @(posedge clk); #1;
    chk("irq_n asserted idle", bus.irq_n, 1'b0);
    bus_write(2'd0, 4'hE, 32'h5A);
    capture_frame(8'h5A, 0, 1'b0, "div0");
    @(posedge clk); #1;
    read_chk("div0 STATUS", 2'd1, 32'h01);
    chk("irq_n at stop end", bus.irq_n, 1'b1);
    @(posedge clk); #1;
    chk("irq_n one clock later", bus.irq_n, 1'b0);

    // Mid-frame asynchronous reset.
    bus_write(2'd2, 4'h0, 32'h4);
    bus_write(2'd0, 4'hE, 32'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("mid-frame tx low", bus.tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("reset tx immediate", bus.tx, 1'b1);
    chk("reset irq_n", bus.irq_n, 1'b1);
    read_chk("reset STATUS", 2'd1, 32'h01);
    read_chk("reset DIV", 2'd2, 32'h10);
    read_chk("reset CTRL", 2'd3, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    watch_idle(20, "post-reset idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
